// File: rtl/prog_loader_if.sv
// Bundles the loader's control strobes, UART byte stream and instruction-memory write port.
// The master side drives the control and byte inputs. The slave side is the loader itself.
interface prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        rx_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, abort, byte_valid, rx_byte,
        input  mem_we, mem_addr, mem_wdata, busy, done, err_code, words_loaded
    );

    modport slave (
        input  start, abort, byte_valid, rx_byte,
        output mem_we, mem_addr, mem_wdata, busy, done, err_code, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Packs a length-prefixed UART byte stream into 32-bit words and writes them to instruction memory.
// The frame is a 16-bit big-endian word count followed by that many big-endian 32-bit words.
module prog_loader #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic          clock,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);
    localparam int          TMO_W   = $clog2(TIMEOUT_CYC);
    localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg,     state_next;
    logic [15:0]       len_reg,       len_next;
    logic [1:0]        byte_cnt_reg,  byte_cnt_next;
    logic [TMO_W-1:0]  tmo_cnt_reg,   tmo_cnt_next;
    logic [23:0]       word_reg,      word_next;
    logic              mem_we_reg,    mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic [1:0]        err_reg,       err_next;
    logic [ADDR_W:0]   wl_reg,        wl_next;

    logic [15:0]       len_full;
    logic              tmo_hit;
    logic              last_word;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            byte_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            word_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            err_reg       <= '0;
            wl_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            byte_cnt_reg  <= byte_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            word_reg      <= word_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            err_reg       <= err_next;
            wl_reg        <= wl_next;
        end
    end

    assign len_full  = {len_reg[15:8], bus.rx_byte};
    // The counter reaches TIMEOUT_CYC-1 on this idle edge.
    assign tmo_hit   = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 2));
    // The word index is the words-loaded count, so it never wraps within a frame.
    assign last_word = ((32'(wl_reg) + 32'd1) == 32'(len_reg));

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        byte_cnt_next  = byte_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        word_next      = word_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        err_next       = err_reg;
        wl_next        = wl_reg;

        if (bus.abort) begin
            state_next    = S_IDLE;
            err_next      = 2'd0;
            byte_cnt_next = '0;
            tmo_cnt_next  = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_next    = S_LEN_HI;
                        err_next      = 2'd0;
                        wl_next       = '0;
                        byte_cnt_next = '0;
                        tmo_cnt_next  = '0;
                        len_next      = '0;
                    end
                end
                S_LEN_HI: begin
                    if (bus.byte_valid) begin
                        len_next[15:8] = bus.rx_byte;
                        tmo_cnt_next   = '0;
                        state_next     = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (bus.byte_valid) begin
                        len_next      = len_full;
                        tmo_cnt_next  = '0;
                        byte_cnt_next = '0;
                        if (len_full == 16'd0) begin
                            state_next = S_DONE;
                        end else if (32'(len_full) > MAX_LEN) begin
                            state_next = S_ERR;
                            err_next   = 2'd1;
                        end else begin
                            state_next = S_DATA;
                        end
                    end else if (tmo_hit) begin
                        state_next = S_ERR;
                        err_next   = 2'd2;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
                S_DATA: begin
                    if (bus.byte_valid) begin
                        tmo_cnt_next  = '0;
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                        word_next     = {word_reg[15:0], bus.rx_byte};
                        if (byte_cnt_reg == 2'd3) begin
                            mem_we_next    = 1'b1;
                            mem_addr_next  = wl_reg[ADDR_W-1:0];
                            mem_wdata_next = {word_reg, bus.rx_byte};
                            wl_next        = wl_reg + 1'b1;
                            if (last_word) begin
                                state_next = S_DONE;
                            end
                        end
                    end else if (tmo_hit) begin
                        // A partially assembled word is simply abandoned.
                        state_next = S_ERR;
                        err_next   = 2'd2;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign bus.mem_we       = mem_we_reg;
    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_wdata    = mem_wdata_reg;
    assign bus.err_code     = err_reg;
    assign bus.words_loaded = wl_reg;
    assign bus.busy         = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) || (state_reg == S_DATA);
    assign bus.done         = (state_reg == S_DONE);
endmodule

// File: tb/tb_prog_loader.sv
// Randomized frames for prog_loader, checked against a frame-level model of the expected memory writes.
// Directed cases cover reset, length overflow, timeout, coincident start and abort behaviour.
module tb_prog_loader;
    localparam int AW   = 4;
    localparam int TMO  = 50;
    localparam int MAXW = 1 << AW;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    prog_loader_if #(.ADDR_W(AW)) bus();

    prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          done;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] frame_q[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata, bus.done});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    // Plays frame_q as one frame and compares against the writes the frame should produce.
    task automatic run_frame(input string tag, input int max_gap, input bit poke_start);
        int len;
        logic [31:0] exp_word;
        wr_q.delete();
        pulse_start();
        foreach (frame_q[i]) begin
            bus.rx_byte    = frame_q[i];
            bus.byte_valid = 1'b1;
            if (poke_start && $urandom_range(0, 3) == 0) bus.start = 1'b1;
            tick();
            bus.byte_valid = 1'b0;
            bus.start      = 1'b0;
            repeat ($urandom_range(0, max_gap)) tick();
        end
        repeat (3) tick();
        len = int'({frame_q[0], frame_q[1]});
        if (len > MAXW) begin
            check({tag, ".err"},    32'(bus.err_code), 32'd1);
            check({tag, ".nwr"},    32'(wr_q.size()), 32'd0);
            check({tag, ".busy"},   32'(bus.busy), 32'd0);
            check({tag, ".wl"},     32'(bus.words_loaded), 32'd0);
        end else begin
            check({tag, ".nwr"}, 32'(wr_q.size()), 32'(len));
            for (int i = 0; i < len && i < wr_q.size(); i++) begin
                exp_word = {frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]};
                check($sformatf("%s.addr%0d", tag, i), 32'(wr_q[i].addr), 32'(i));
                check($sformatf("%s.data%0d", tag, i), wr_q[i].data, exp_word);
            end
            if (len > 0 && wr_q.size() > 0)
                check({tag, ".lastdone"}, 32'(wr_q[wr_q.size()-1].done), 32'd1);
            check({tag, ".done"}, 32'(bus.done), 32'd1);
            check({tag, ".err"},  32'(bus.err_code), 32'd0);
            check({tag, ".busy"}, 32'(bus.busy), 32'd0);
            check({tag, ".wl"},   32'(bus.words_loaded), 32'(len));
        end
        $display("frame %s len=%0d writes=%0d", tag, len, wr_q.size());
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".we"},    32'(bus.mem_we), 32'd0);
        check({tag, ".addr"},  32'(bus.mem_addr), 32'd0);
        check({tag, ".wdata"}, bus.mem_wdata, 32'd0);
        check({tag, ".busy"},  32'(bus.busy), 32'd0);
        check({tag, ".done"},  32'(bus.done), 32'd0);
        check({tag, ".err"},   32'(bus.err_code), 32'd0);
        check({tag, ".wl"},    32'(bus.words_loaded), 32'd0);
    endtask

    initial begin
        int n;
        int len;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.rx_byte    = 8'h00;

        #12;
        check_idle_zero("reset");
        @(posedge clock);
        #1 rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a data word.
        wr_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        @(posedge clock);
        #1 rst_n = 1'b1;
        tick();
        check("rst_mid.nwr", 32'(wr_q.size()), 32'd0);

        frame_q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        run_frame("two_words", 2, 1'b0);
        pulse_abort();
        check("abort_done.wl",   32'(bus.words_loaded), 32'd2);
        check("abort_done.done", 32'(bus.done), 32'd0);

        frame_q = '{8'h00, 8'h00};
        run_frame("len_zero", 2, 1'b0);

        frame_q = '{8'h00, 8'h11};
        run_frame("overflow", 2, 1'b0);

        frame_q = '{8'h00, 8'h10};
        for (int i = 0; i < 4 * MAXW; i++) frame_q.push_back(8'($urandom));
        run_frame("max_len", 1, 1'b0);

        // No timeout while waiting for the first length byte.
        pulse_start();
        repeat (3 * TMO) tick();
        check("lenhi_wait.busy", 32'(bus.busy), 32'd1);
        check("lenhi_wait.err",  32'(bus.err_code), 32'd0);
        pulse_abort();
        check("abort.busy", 32'(bus.busy), 32'd0);

        // Timeout in DATA after a partial word.
        wr_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        n = 0;
        while (bus.err_code != 2'd2 && n < 4 * TMO) begin
            tick();
            n++;
        end
        check("timeout.cycles", 32'(n), 32'(TMO - 1));
        check("timeout.err",    32'(bus.err_code), 32'd2);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        repeat (2) tick();
        check("timeout.nwr",  32'(wr_q.size()), 32'd0);
        check("timeout.hold", 32'(bus.err_code), 32'd2);
        check("timeout.busy", 32'(bus.busy), 32'd0);

        // start and byte_valid together: the byte is dropped, so 01 DE becomes the length.
        wr_q.delete();
        bus.start = 1'b1; bus.byte_valid = 1'b1; bus.rx_byte = 8'h00;
        tick();
        bus.start = 1'b0;
        bus.rx_byte = 8'h01; tick();
        bus.rx_byte = 8'hDE; tick();
        bus.rx_byte = 8'hAD; tick();
        bus.rx_byte = 8'hBE; tick();
        bus.rx_byte = 8'hEF; tick();
        bus.byte_valid = 1'b0;
        repeat (2) tick();
        check("coincide.err", 32'(bus.err_code), 32'd1);
        check("coincide.nwr", 32'(wr_q.size()), 32'd0);

        frame_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("resend", 0, 1'b0);

        // Abort mid-word.
        wr_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
        pulse_abort();
        repeat (2) tick();
        check("abort_mid.busy", 32'(bus.busy), 32'd0);
        check("abort_mid.err",  32'(bus.err_code), 32'd0);
        check("abort_mid.done", 32'(bus.done), 32'd0);
        check("abort_mid.nwr",  32'(wr_q.size()), 32'd0);

        // Random frames with random gaps and stray start pulses while busy.
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(0, 9);
            if (n == 0)      len = 0;
            else if (n == 1) len = $urandom_range(MAXW + 1, 65535);
            else             len = $urandom_range(1, MAXW);
            frame_q.delete();
            frame_q.push_back(8'(len >> 8));
            frame_q.push_back(8'(len));
            if (len <= MAXW)
                for (int i = 0; i < 4 * len; i++) frame_q.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", f), 5, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: packs bytes from the UART receiver into 32-bit instruction words and writes them to instruction memory, so the CPU fetch/decode path can execute them.
- Sits between the UART byte receiver and the instruction-memory write port.
- While busy=1 the CPU is held off and the loader owns the memory port.
- Frame format: 16-bit word count (MSB byte first), then count x 4 bytes, each word MSB byte first.

Parameters:
ADDR_W, 14, instruction-memory word-address width; maximum accepted count is 2^ADDR_W.
TIMEOUT_CYC, 1000000, idle cycles allowed between bytes once a frame has started; values ≥2 only.

Ports:
clock  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms loader (honoured in IDLE, DONE, ERR)
abort  input  1  one-cycle pulse; returns to IDLE from any state
byte_valid  input  1  one-cycle strobe: rx_byte is valid this cycle
rx_byte  input  8  received byte
mem_we  output  1  instruction-memory write enable, one-cycle pulse
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word written
busy  output  1  high in LEN_HI, LEN_LO, DATA
done  output  1  high in DONE
err_code  output  2  0 none, 1 length overflow, 2 timeout; holds until next start/abort
words_loaded  output  ADDR_W+1  count of words written in the current frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_code=0, words_loaded=0; internal length, byte counter and timeout counter all 0.
- State: IDLE --start--> LEN_HI.
- State: LEN_HI --byte--> LEN_LO (stores len[15:8]).
- State: LEN_LO --byte--> evaluates len:
  - len==0 -> DONE.
  - len > 2^ADDR_W -> ERR, err_code=1.
  - otherwise -> DATA.
- State: DATA --4th byte of last word--> DONE. DONE and ERR --start--> LEN_HI.
- start from DONE/ERR clears err_code, words_loaded, byte counter and word index.
- abort has priority over every other input. Next cycle: state=IDLE, err_code=0, mem_we=0. words_loaded is held.
- start together with byte_valid in IDLE/DONE/ERR: start is taken, the byte is dropped.
- byte_valid in IDLE, DONE or ERR is ignored.
- start while busy is ignored.
- DATA packing: byte k (k=0..3) lands at word bits [31-8k -: 8]; k is a 2-bit counter that wraps 3->0.
- Write latency: on the cycle after byte 3 is accepted:
  - mem_we=1 for exactly one cycle;
  - mem_addr = word index and mem_wdata = the assembled word;
  - words_loaded increments in the same cycle.
- Word index starts at 0 and increments after each write. mem_addr/mem_wdata hold their last values while mem_we=0.
- Last word: its write pulse coincides with the first DONE cycle, so done and mem_we are both 1 for that cycle.
- Back-to-back bytes (byte_valid on consecutive cycles) are accepted with no loss.
- Timeout counter:
  - active in LEN_LO and DATA only, so waiting for the first length byte never times out;
  - cleared on every accepted byte, incremented otherwise.
  - Reaching TIMEOUT_CYC-1 -> ERR, err_code=2. The partial word is discarded and no write is issued.
- Address range: len == 2^ADDR_W is legal. The final write goes to address 2^ADDR_W-1 and the word index never wraps within a frame.

Test Plan:
- Reset mid-DATA (rst_n low asynchronously after 2 data bytes) -> all outputs 0 immediately, no mem_we, state IDLE; the next start works normally.
- start; bytes 00 02 | 24 08 00 05 | 00 00 00 08 -> two mem_we pulses:
  - addr 0 data 0x24080005;
  - addr 1 data 0x00000008.
  - done=1 in the cycle of the second pulse; words_loaded=2; busy low afterwards.
- start; bytes 00 00 -> DONE after second byte, no mem_we, words_loaded=0.
- ADDR_W=4; start; bytes 00 11 -> ERR, err_code=1, no writes. Then start; bytes 00 10 + 64 bytes -> 16 writes, last at addr 15.
- TIMEOUT_CYC=50; start; bytes 00 01 AA BB, then silence -> err_code=2 exactly 49 idle cycles after BB, no write. Byte_valid afterwards is ignored.
- Back-to-back bytes 00 01 DE AD BE EF on consecutive cycles, with start and byte_valid coincident on the first cycle -> the first byte is dropped. Resend on clean cycles -> one write of 0xDEADBEEF. An abort mid-word -> IDLE, no write.
